// File: rtl/datapath_mem_responder.sv
// rtl/datapath_mem_responder.sv - blocking single-port RAM responder for datapath fetch/load/store
//
// Purpose: serves one instruction fetch or data access at a time on a single-port
// word RAM. Data requests win arbitration. Each access is guarded by a timeout that
// forces completion with ERR_WORD and raises a sticky error flag.
//
// Ports:
//   CLK, nRST                          clock (rising), async active-low reset
//   halt                               blocks new instruction fetches
//   imemREN, imemaddr -> imemload, ihit          instruction fetch request / response
//   dmemREN, dmemWEN, dmemaddr, dmemstore
//                     -> dmemload, dhit          data access request / response
//   ramREN, ramWEN, ramaddr, ramstore  RAM strobes, word address, write data
//   ramload, ramready                  RAM read data and completion pulse
//   timeout_err                        sticky: an access timed out
module datapath_mem_responder #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, IACC, DACC, IRESP, DRESP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_q, abort_d;
  logic          terr_q, terr_d;
  logic [31:0]   iload_q, iload_d;
  logic [31:0]   dload_q, dload_d;

  logic req_live;
  logic expired;

  // Address bits [1:0] are dropped: the RAM is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imemaddr[1:0], dmemaddr[1:0]};

  // The requester still wants the access currently in flight.
  assign req_live = (state_q == DACC) ? (dmemREN | dmemWEN) : imemREN;
  assign expired  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    terr_d   = terr_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      IDLE: begin
        if (dmemREN | dmemWEN) begin
          state_d = DACC;
          addr_d  = {dmemaddr[31:2], 2'b00};
          wdata_d = dmemstore;
          rd_d    = dmemREN;          // read wins when both are raised
          cnt_d   = '0;
          abort_d = 1'b0;
        end else if (imemREN && !halt) begin
          state_d = IACC;
          addr_d  = {imemaddr[31:2], 2'b00};
          wdata_d = '0;
          rd_d    = 1'b1;
          cnt_d   = '0;
          abort_d = 1'b0;
        end
      end

      IACC, DACC: begin
        ramaddr  = addr_q;
        ramREN   = rd_q;
        ramWEN   = !rd_q;
        ramstore = rd_q ? 32'h0 : wdata_q;
        // A dropped request only suppresses the hit; the RAM cycle still finishes.
        abort_d  = abort_q | !req_live;
        if (ramready || expired) begin
          state_d = (state_q == IACC) ? IRESP : DRESP;
          if (rd_q) begin
            if (state_q == IACC) iload_d = ramready ? ramload : ERR_WORD;
            else                 dload_d = ramready ? ramload : ERR_WORD;
          end
          if (!ramready) terr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      IRESP, DRESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      terr_q  <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      terr_q  <= terr_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
    end
  end

  assign ihit        = (state_q == IRESP) && !abort_q;
  assign dhit        = (state_q == DRESP) && !abort_q;
  assign imemload    = iload_q;
  assign dmemload    = dload_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_datapath_mem_responder.sv
// tb/tb_datapath_mem_responder.sv - directed self-checking bench for datapath_mem_responder
module tb_datapath_mem_responder;

  logic        CLK, nRST, halt;
  logic        imemREN, dmemREN, dmemWEN, ramready;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;

  logic [31:0] imemload, dmemload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, timeout_err;

  logic [31:0] t_imemload, t_dmemload, t_ramaddr, t_ramstore;
  logic        t_ihit, t_dhit, t_ramREN, t_ramWEN, t_timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  datapath_mem_responder dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmemload(dmemload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .timeout_err(timeout_err)
  );

  datapath_mem_responder #(.TIMEOUT(8)) dut_t (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(t_imemload), .ihit(t_ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmemload(t_dmemload), .dhit(t_dhit),
    .ramREN(t_ramREN), .ramWEN(t_ramWEN), .ramaddr(t_ramaddr), .ramstore(t_ramstore),
    .ramload(ramload), .ramready(ramready), .timeout_err(t_timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    step();
    step();
    nRST = 1'b1;
    step();
  endtask

  int n;

  initial begin
    nRST = 1'b0; halt = 1'b0; imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    ramready = 1'b0; imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramload = '0;
    #2;
    check_eq("rst_ramREN", ramREN, 0);
    check_eq("rst_ramWEN", ramWEN, 0);
    check_eq("rst_ramaddr", ramaddr, 0);
    check_eq("rst_ramstore", ramstore, 0);
    check_eq("rst_ihit", ihit, 0);
    check_eq("rst_dhit", dhit, 0);
    check_eq("rst_imemload", imemload, 0);
    check_eq("rst_dmemload", dmemload, 0);
    check_eq("rst_terr", timeout_err, 0);
    step();
    nRST = 1'b1;
    step();

    // Instruction fetch, RAM ready on first access cycle
    imemREN = 1'b1; imemaddr = 32'h4;
    step();
    check_eq("if_ramREN", ramREN, 1);
    check_eq("if_ramaddr", ramaddr, 32'h4);
    check_eq("if_ramWEN", ramWEN, 0);
    ramready = 1'b1; ramload = 32'h8C220000;
    step();
    ramready = 1'b0;
    check_eq("if_ihit", ihit, 1);
    check_eq("if_imemload", imemload, 32'h8C220000);
    check_eq("if_ramREN_off", ramREN, 0);
    imemREN = 1'b0;
    step();
    check_eq("if_ihit_pulse", ihit, 0);

    // Data write wins over a simultaneous fetch; fetch follows
    imemREN = 1'b1; imemaddr = 32'h8;
    dmemWEN = 1'b1; dmemaddr = 32'h103; dmemstore = 32'hDEADBEEF;
    step();
    check_eq("pr_ramWEN", ramWEN, 1);
    check_eq("pr_ramREN", ramREN, 0);
    check_eq("pr_ramaddr", ramaddr, 32'h100);
    check_eq("pr_ramstore", ramstore, 32'hDEADBEEF);
    ramready = 1'b1;
    step();
    ramready = 1'b0;
    check_eq("pr_dhit", dhit, 1);
    check_eq("pr_ihit", ihit, 0);
    check_eq("pr_dmemload_kept", dmemload, 0);
    dmemWEN = 1'b0;
    step();
    check_eq("pr_idle_gap", ramREN | ramWEN | dhit, 0);
    step();
    check_eq("pr_if_ramREN", ramREN, 1);
    check_eq("pr_if_ramaddr", ramaddr, 32'h8);
    check_eq("pr_if_ramstore", ramstore, 0);
    ramready = 1'b1; ramload = 32'h11112222;
    step();
    ramready = 1'b0;
    check_eq("pr_if_ihit", ihit, 1);
    check_eq("pr_if_imemload", imemload, 32'h11112222);
    imemREN = 1'b0;
    step();

    // Slow RAM: ready on the 10th access cycle; address change mid-access ignored
    dmemREN = 1'b1; dmemaddr = 32'h20;
    step();
    dmemaddr = 32'h44;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      if (ramREN) n++;
      step();
    end
    if (ramREN) n++;
    check_eq("slow_ramaddr", ramaddr, 32'h20);
    ramready = 1'b1; ramload = 32'h12345678;
    step();
    ramready = 1'b0;
    check_eq("slow_strobe_cycles", n, 10);
    check_eq("slow_dhit", dhit, 1);
    check_eq("slow_dmemload", dmemload, 32'h12345678);
    check_eq("slow_terr", timeout_err, 0);
    dmemREN = 1'b0;
    step();

    // Halt blocks fetch entry
    halt = 1'b1; imemREN = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ramREN) n++;
    end
    check_eq("halt_no_ramREN", n, 0);
    imemREN = 1'b0; halt = 1'b0;
    step();

    // Abort: dmemREN dropped mid-access
    dmemREN = 1'b1; dmemaddr = 32'h30;
    step();
    check_eq("ab_ramREN", ramREN, 1);
    dmemREN = 1'b0;
    step();
    check_eq("ab_ramREN_held", ramREN, 1);
    ramready = 1'b1; ramload = 32'hCAFEF00D;
    step();
    ramready = 1'b0;
    check_eq("ab_no_dhit", dhit, 0);
    check_eq("ab_dmemload", dmemload, 32'hCAFEF00D);
    step();
    check_eq("ab_idle", ramREN | dhit, 0);

    // Timeout on the TIMEOUT=8 instance
    do_reset();
    dmemREN = 1'b1; dmemaddr = 32'h50;
    step();
    n = 0;
    for (int i = 0; i < 20 && !t_dhit; i++) begin
      if (t_ramREN) n++;
      step();
    end
    check_eq("to_strobe_cycles", n, 8);
    check_eq("to_dhit", t_dhit, 1);
    check_eq("to_dmemload", t_dmemload, 32'hBAD1BAD1);
    check_eq("to_terr", t_timeout_err, 1);
    dmemREN = 1'b0; ramready = 1'b1;
    step();
    ramready = 1'b0;
    step();
    step();
    check_eq("to_terr_sticky", t_timeout_err, 1);
    check_eq("to_main_terr", timeout_err, 0);

    // ramready on the final allowed cycle beats the timeout
    do_reset();
    check_eq("to_terr_reset", t_timeout_err, 0);
    dmemREN = 1'b1;
    step();
    for (int i = 0; i < 7; i++) step();
    check_eq("edge_ramREN", t_ramREN, 1);
    ramready = 1'b1; ramload = 32'h55AA55AA;
    step();
    ramready = 1'b0;
    check_eq("edge_dhit", t_dhit, 1);
    check_eq("edge_dmemload", t_dmemload, 32'h55AA55AA);
    check_eq("edge_terr", t_timeout_err, 0);
    dmemREN = 1'b0;
    step();

    // Reset mid-access, then a normal fetch
    dmemREN = 1'b1; dmemaddr = 32'h60;
    step();
    check_eq("rm_ramREN", ramREN, 1);
    nRST = 1'b0;
    #1;
    check_eq("rm_ramREN_off", ramREN, 0);
    check_eq("rm_ramaddr_off", ramaddr, 0);
    check_eq("rm_dmemload", dmemload, 0);
    dmemREN = 1'b0;
    step();
    check_eq("rm_no_dhit", dhit, 0);
    nRST = 1'b1;
    step();
    imemREN = 1'b1; imemaddr = 32'h42;
    step();
    check_eq("rm_if_ramREN", ramREN, 1);
    check_eq("rm_if_ramaddr", ramaddr, 32'h40);
    ramready = 1'b1; ramload = 32'h0A0B0C0D;
    step();
    ramready = 1'b0;
    check_eq("rm_if_ihit", ihit, 1);
    check_eq("rm_if_imemload", imemload, 32'h0A0B0C0D);
    imemREN = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
